// File: rtl/prng_rr_scheduler_if.sv
// Seed handshake, request/grant and status bundle of prng_rr_scheduler.
// slave is the scheduler side, master is the seed source / requester side.
interface prng_rr_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int RND_W   = 64
);
   logic               seed_valid_i;
   logic               seed_ready_o;
   logic [127:0]       seed_i;
   logic [NUM_REQ-1:0] req_i;
   logic [NUM_REQ-1:0] gnt_o;
   logic [RND_W-1:0]   rnd_o;
   logic               reseed_req_o;
   logic               zero_err_o;

   modport master (
      output seed_valid_i, seed_i, req_i,
      input  seed_ready_o, gnt_o, rnd_o, reseed_req_o, zero_err_o
   );

   modport slave (
      input  seed_valid_i, seed_i, req_i,
      output seed_ready_o, gnt_o, rnd_o, reseed_req_o, zero_err_o
   );
endinterface

// File: rtl/prng_rr_scheduler.sv
// Seed/warmup sequencer and round-robin grant arbiter for the 128-bit masking PRNG.
// Optional all-zero LFSR guard: define PRNG_ZERO_GUARD_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------
// UNSEEDED   | no valid seed, waiting for seed handshake
// LOAD       | prng_init_o pulse, seed copied into the LFSR
// WARMUP     | prng_en_o for WARMUP cycles before the first grant
// READY      | may grant one requester per cycle (or accept a reseed)
// STRIDE     | prng_en_o for STRIDE-1 cycles after a grant, no grants
// STALE      | grant budget spent, reseed_req_o until a new seed arrives
module prng_rr_scheduler #(
   parameter int NUM_REQ         = 4,
   parameter int RND_W           = 64,
   parameter int WARMUP          = 128,
   parameter int STRIDE          = 8,
   parameter int RESEED_INTERVAL = 1024
) (
   input  logic                clk,
   input  logic                rst,
   prng_rr_scheduler_if.slave  bus_if,
   output logic                prng_init_o,
   output logic                prng_en_o,
   output logic [127:0]        prng_seed_o,
   input  logic [127:0]        prng_i
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int IW    = PTR_W + 1;

   localparam logic [2:0] S_UNSEEDED = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_WARMUP   = 3'd2;
   localparam logic [2:0] S_READY    = 3'd3;
   localparam logic [2:0] S_STRIDE   = 3'd4;
   localparam logic [2:0] S_STALE    = 3'd5;

   localparam logic [31:0]      WARMUP_LOAD = 32'(WARMUP - 1);
   localparam logic [31:0]      STRIDE_LOAD = (STRIDE > 1) ? 32'(STRIDE - 2) : 32'd0;
   localparam logic [31:0]      RESEED_CNT  = 32'(RESEED_INTERVAL);
   localparam logic [PTR_W-1:0] PTR_RST     = PTR_W'(NUM_REQ - 1);

   logic [2:0]         state_q, state_d;
   logic [31:0]        tmr_q, tmr_d;
   logic [31:0]        gcnt_q, gcnt_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [127:0]       seed_q, seed_d;
   logic               zero_err_q, zero_err_d;

   logic               seed_hs;
   logic               prng_zero;
   logic               found;
   logic               grant_en;
   logic               en;
   logic [PTR_W-1:0]   win_idx;
   logic [NUM_REQ-1:0] gnt;
   logic [31:0]        gcnt_inc;
   logic               unused_prng;

   assign bus_if.seed_ready_o = (state_q == S_UNSEEDED) || (state_q == S_READY) ||
                                (state_q == S_STALE);
   assign seed_hs = bus_if.seed_valid_i && bus_if.seed_ready_o;

`ifdef PRNG_ZERO_GUARD_EN
   assign prng_zero = (prng_i == 128'd0);
`else
   assign prng_zero = 1'b0;
`endif

   // Only prng_i[RND_W-1:0] is delivered; the reduction keeps the upper bits referenced.
   assign unused_prng = ^prng_i;

   // First set request scanning upward from ptr+1, wrapping at NUM_REQ.
   always_comb begin
      logic [IW-1:0] idx;
      idx     = '0;
      found   = 1'b0;
      win_idx = ptr_q;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = {1'b0, ptr_q} + IW'(i);
         if (idx >= IW'(NUM_REQ)) begin
            idx = idx - IW'(NUM_REQ);
         end
         if (!found && bus_if.req_i[idx[PTR_W-1:0]]) begin
            found   = 1'b1;
            win_idx = idx[PTR_W-1:0];
         end
      end
   end

   assign grant_en = (state_q == S_READY) && !seed_hs && !prng_zero && found;
   assign gcnt_inc = (gcnt_q == '1) ? gcnt_q : gcnt_q + 32'd1;

   always_comb begin
      gnt = '0;
      if (grant_en) begin
         gnt[win_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      gcnt_d     = gcnt_q;
      ptr_d      = ptr_q;
      seed_d     = seed_q;
      zero_err_d = zero_err_q;
      en         = 1'b0;

      if (seed_hs) begin
         seed_d     = bus_if.seed_i;
         gcnt_d     = '0;
         zero_err_d = 1'b0;
         state_d    = S_LOAD;
      end

      case (state_q)
         S_LOAD: begin
            state_d = S_WARMUP;
            tmr_d   = WARMUP_LOAD;
         end
         S_WARMUP: begin
            en = 1'b1;
            if (tmr_q == '0) begin
               state_d = S_READY;
            end else begin
               tmr_d = tmr_q - 32'd1;
            end
         end
         S_READY: begin
            if (!seed_hs) begin
               if (prng_zero) begin
                  zero_err_d = 1'b1;
                  state_d    = S_UNSEEDED;
               end else if (found) begin
                  en     = 1'b1;
                  ptr_d  = win_idx;
                  gcnt_d = gcnt_inc;
                  if (STRIDE > 1) begin
                     state_d = S_STRIDE;
                     tmr_d   = STRIDE_LOAD;
                  end else if ((RESEED_INTERVAL != 0) && (gcnt_inc == RESEED_CNT)) begin
                     state_d = S_STALE;
                  end
               end
            end
         end
         S_STRIDE: begin
            en = 1'b1;
            if (tmr_q == '0) begin
               if ((RESEED_INTERVAL != 0) && (gcnt_q == RESEED_CNT)) begin
                  state_d = S_STALE;
               end else begin
                  state_d = S_READY;
               end
            end else begin
               tmr_d = tmr_q - 32'd1;
            end
         end
         S_UNSEEDED, S_STALE: begin
         end
         default: begin
            state_d = S_UNSEEDED;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_UNSEEDED;
         tmr_q      <= '0;
         gcnt_q     <= '0;
         ptr_q      <= PTR_RST;
         seed_q     <= '0;
         zero_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         gcnt_q     <= gcnt_d;
         ptr_q      <= ptr_d;
         seed_q     <= seed_d;
         zero_err_q <= zero_err_d;
      end
   end

   assign bus_if.gnt_o        = gnt;
   assign bus_if.rnd_o        = grant_en ? prng_i[RND_W-1:0] : '0;
   assign bus_if.reseed_req_o = (state_q == S_STALE);
   assign bus_if.zero_err_o   = zero_err_q;
   assign prng_init_o         = (state_q == S_LOAD);
   assign prng_en_o           = en;
   assign prng_seed_o         = seed_q;

endmodule

// File: tb/tb_prng_rr_scheduler.sv
// Bench for prng_rr_scheduler: two instances (STRIDE=8 no reseed, STRIDE=1 reseed every 3)
// driving a small LFSR stub; expected grants are queued at stimulus time and popped on gnt_o.
module tb_prng_rr_scheduler;
   localparam int NR = 4;
   localparam int RW = 64;
   localparam int WU = 4;
   localparam logic [127:0] S1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] S2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
   localparam logic [127:0] S3 = 128'h0F0F_1234_A5A5_5A5A_9876_FEDC_0001_8000;

   typedef struct {
      int            cyc;
      logic [NR-1:0] gnt;
      logic [RW-1:0] rnd;
   } exp_t;

   exp_t sb_q[$];

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   prng_rr_scheduler_if #(.NUM_REQ(NR), .RND_W(RW)) ifa ();
   prng_rr_scheduler_if #(.NUM_REQ(NR), .RND_W(RW)) ifb ();

   logic         a_init, a_en, b_init, b_en;
   logic [127:0] a_seed, b_seed;
   logic [127:0] a_prng, b_prng;

   prng_rr_scheduler #(.NUM_REQ(NR), .RND_W(RW), .WARMUP(WU), .STRIDE(8), .RESEED_INTERVAL(0)) dut_a (
      .clk(clk), .rst(rst), .bus_if(ifa),
      .prng_init_o(a_init), .prng_en_o(a_en), .prng_seed_o(a_seed), .prng_i(a_prng));

   prng_rr_scheduler #(.NUM_REQ(NR), .RND_W(RW), .WARMUP(WU), .STRIDE(1), .RESEED_INTERVAL(3)) dut_b (
      .clk(clk), .rst(rst), .bus_if(ifb),
      .prng_init_o(b_init), .prng_en_o(b_en), .prng_seed_o(b_seed), .prng_i(b_prng));

   function automatic logic [127:0] lfsr_step(input logic [127:0] s);
      return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
   endfunction

   function automatic logic [RW-1:0] lfsr_rnd(input logic [127:0] s, input int n);
      logic [127:0] r;
      r = s;
      for (int i = 0; i < n; i++) r = lfsr_step(r);
      return r[RW-1:0];
   endfunction

   // PRNG stubs: load on init, advance on enable.
   always @(posedge clk or posedge rst)
      if (rst) a_prng <= '0;
      else if (a_init) a_prng <= a_seed;
      else if (a_en) a_prng <= lfsr_step(a_prng);

   always @(posedge clk or posedge rst)
      if (rst) b_prng <= '0;
      else if (b_init) b_prng <= b_seed;
      else if (b_en) b_prng <= lfsr_step(b_prng);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      ifa.seed_valid_i = 1'b0; ifa.seed_i = '0; ifa.req_i = '0;
      ifb.seed_valid_i = 1'b0; ifb.seed_i = '0; ifb.req_i = '0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      n_chk++; if (ifa.gnt_o !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", ifa.gnt_o); end
      n_chk++; if (ifa.rnd_o !== '0) begin n_fail++; $display("FAIL reset_rnd: got %h want 0", ifa.rnd_o); end
      n_chk++; if (ifa.reseed_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_reseed: got %b want 0", ifa.reseed_req_o); end
      n_chk++; if (ifa.zero_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_zero_err: got %b want 0", ifa.zero_err_o); end
      n_chk++; if ({a_init, a_en} !== 2'b00) begin n_fail++; $display("FAIL reset_init_en: got %b want 00", {a_init, a_en}); end
      n_chk++; if (a_seed !== '0) begin n_fail++; $display("FAIL reset_seed: got %h want 0", a_seed); end
      n_chk++; if ({ifa.seed_ready_o, ifb.seed_ready_o} !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b want 11", {ifa.seed_ready_o, ifb.seed_ready_o}); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_warmup_timing();
      ifa.seed_valid_i = 1'b1; ifa.seed_i = S1;
      @(negedge clk);
      n_chk++; if (ifa.seed_ready_o !== 1'b1) begin n_fail++; $display("FAIL wu_ready_unseeded: got %b want 1", ifa.seed_ready_o); end
      for (int c = 1; c <= WU + 3; c++) begin
         step();
         ifa.seed_valid_i = 1'b0;
         @(negedge clk);
         n_chk++; if (a_init !== (c == 1)) begin n_fail++; $display("FAIL wu_init T+%0d: got %b want %b", c, a_init, (c == 1)); end
         n_chk++; if (a_en !== (c >= 2 && c <= WU + 1)) begin n_fail++; $display("FAIL wu_en T+%0d: got %b want %b", c, a_en, (c >= 2 && c <= WU + 1)); end
         n_chk++; if (ifa.seed_ready_o !== (c >= WU + 2)) begin n_fail++; $display("FAIL wu_ready T+%0d: got %b want %b", c, ifa.seed_ready_o, (c >= WU + 2)); end
      end
      n_chk++; if (a_seed !== S1) begin n_fail++; $display("FAIL wu_seed_reg: got %h want %h", a_seed, S1); end
      step();
   endtask

   task automatic test_round_robin();
      exp_t e;
      int   c0;
      logic idle_bad;
      c0 = cyc;
      idle_bad = 1'b0;
      sb_q.delete();
      ifa.req_i = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         e.cyc = c0 + i * 8;
         e.gnt = '0;
         e.gnt[i % NR] = 1'b1;
         e.rnd = lfsr_rnd(S1, WU + i * 8);
         sb_q.push_back(e);
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ifa.gnt_o !== '0) begin
            if (sb_q.size() == 0) begin
               n_chk++; n_fail++; $display("FAIL rr_extra_grant: got %b at cycle %0d want none", ifa.gnt_o, cyc);
            end else begin
               e = sb_q.pop_front();
               n_chk++; if (cyc !== e.cyc) begin n_fail++; $display("FAIL rr_cycle: got %0d want %0d", cyc, e.cyc); end
               n_chk++; if (ifa.gnt_o !== e.gnt) begin n_fail++; $display("FAIL rr_gnt: got %b want %b", ifa.gnt_o, e.gnt); end
               n_chk++; if (ifa.rnd_o !== e.rnd) begin n_fail++; $display("FAIL rr_rnd: got %h want %h", ifa.rnd_o, e.rnd); end
               n_chk++; if (a_en !== 1'b1) begin n_fail++; $display("FAIL rr_en: got %b want 1", a_en); end
            end
         end else if (ifa.rnd_o !== '0) begin
            idle_bad = 1'b1;
         end
         step();
      end
      n_chk++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL rr_missing: got %0d grants outstanding want 0", sb_q.size()); end
      n_chk++; if (idle_bad !== 1'b0) begin n_fail++; $display("FAIL rr_rnd_idle: got nonzero rnd_o without grant want 0"); end
      ifa.req_i = '0;
   endtask

   task automatic test_seed_priority();
      logic [RW-1:0] exp_rnd;
      ifa.seed_valid_i = 1'b1; ifa.seed_i = S2; ifa.req_i = 4'b0010;
      @(negedge clk);
      n_chk++; if (ifa.gnt_o !== '0) begin n_fail++; $display("FAIL prio_no_grant: got %b want 0", ifa.gnt_o); end
      n_chk++; if (a_en !== 1'b0) begin n_fail++; $display("FAIL prio_en: got %b want 0", a_en); end
      step();
      ifa.seed_valid_i = 1'b0; ifa.req_i = '0;
      @(negedge clk);
      n_chk++; if (a_init !== 1'b1) begin n_fail++; $display("FAIL prio_load: got %b want 1", a_init); end
      n_chk++; if (a_seed !== S2) begin n_fail++; $display("FAIL prio_seed: got %h want %h", a_seed, S2); end
      repeat (WU + 1) step();
      ifa.req_i = 4'b1111;
      exp_rnd = lfsr_rnd(S2, WU);
      @(negedge clk);
      n_chk++; if (ifa.gnt_o !== 4'b0010) begin n_fail++; $display("FAIL prio_ptr_kept: got %b want 0010", ifa.gnt_o); end
      n_chk++; if (ifa.rnd_o !== exp_rnd) begin n_fail++; $display("FAIL prio_rnd: got %h want %h", ifa.rnd_o, exp_rnd); end
      step();
      ifa.req_i = '0;
   endtask

   task automatic test_reset_mid_stride();
      logic [RW-1:0] exp_rnd;
      step();
      n_chk++; if (a_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stride_en: got %b want 1", a_en); end
      #2 rst = 1'b1;
      #1;
      n_chk++; if ({a_init, a_en, ifa.reseed_req_o, ifa.zero_err_o} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b want 0000", {a_init, a_en, ifa.reseed_req_o, ifa.zero_err_o}); end
      n_chk++; if (a_seed !== '0) begin n_fail++; $display("FAIL rst_mid_seed: got %h want 0", a_seed); end
      n_chk++; if (ifa.seed_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", ifa.seed_ready_o); end
      n_chk++; if ({ifa.gnt_o, ifa.rnd_o} !== '0) begin n_fail++; $display("FAIL rst_mid_gnt_rnd: got %b/%h want 0", ifa.gnt_o, ifa.rnd_o); end
      rst = 1'b0;
      step();
      ifa.seed_valid_i = 1'b1; ifa.seed_i = S1;
      step();
      ifa.seed_valid_i = 1'b0;
      repeat (WU + 1) step();
      ifa.req_i = 4'b1111;
      exp_rnd = lfsr_rnd(S1, WU);
      @(negedge clk);
      n_chk++; if (ifa.gnt_o !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr: got %b want 0001", ifa.gnt_o); end
      n_chk++; if (ifa.rnd_o !== exp_rnd) begin n_fail++; $display("FAIL rst_rnd: got %h want %h", ifa.rnd_o, exp_rnd); end
      step();
      ifa.req_i = '0;
   endtask

   task automatic test_zero_guard();
      repeat (7) step();
      ifa.seed_valid_i = 1'b1; ifa.seed_i = '0;
      step();
      ifa.seed_valid_i = 1'b0;
      repeat (WU + 1) step();
      ifa.req_i = 4'b1111;
      @(negedge clk);
`ifdef PRNG_ZERO_GUARD_EN
      n_chk++; if (ifa.gnt_o !== '0) begin n_fail++; $display("FAIL zg_no_grant: got %b want 0", ifa.gnt_o); end
      n_chk++; if (a_en !== 1'b0) begin n_fail++; $display("FAIL zg_en: got %b want 0", a_en); end
      step();
      @(negedge clk);
      n_chk++; if (ifa.zero_err_o !== 1'b1) begin n_fail++; $display("FAIL zg_err_set: got %b want 1", ifa.zero_err_o); end
      n_chk++; if ({ifa.seed_ready_o, ifa.gnt_o} !== {1'b1, 4'b0000}) begin n_fail++; $display("FAIL zg_unseeded: got ready=%b gnt=%b want 1/0000", ifa.seed_ready_o, ifa.gnt_o); end
      step();
      ifa.seed_valid_i = 1'b1; ifa.seed_i = S3;
      step();
      ifa.seed_valid_i = 1'b0; ifa.req_i = '0;
      @(negedge clk);
      n_chk++; if (ifa.zero_err_o !== 1'b0) begin n_fail++; $display("FAIL zg_err_clear: got %b want 0", ifa.zero_err_o); end
      n_chk++; if (a_init !== 1'b1) begin n_fail++; $display("FAIL zg_reload: got %b want 1", a_init); end
`else
      n_chk++; if (ifa.gnt_o !== 4'b0010) begin n_fail++; $display("FAIL zg_grant: got %b want 0010", ifa.gnt_o); end
      n_chk++; if (ifa.rnd_o !== '0) begin n_fail++; $display("FAIL zg_rnd: got %h want 0", ifa.rnd_o); end
      n_chk++; if (ifa.zero_err_o !== 1'b0) begin n_fail++; $display("FAIL zg_err: got %b want 0", ifa.zero_err_o); end
`endif
      step();
      ifa.req_i = '0;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   t;
      t = cyc;
      sb_q.delete();
      ifb.seed_valid_i = 1'b1; ifb.seed_i = S3;
      step();
      ifb.seed_valid_i = 1'b0; ifb.req_i = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         e.cyc = t + WU + 2 + i;
         e.gnt = (i == 1) ? 4'b0100 : 4'b0001;
         e.rnd = lfsr_rnd(S3, WU + i);
         sb_q.push_back(e);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (ifb.gnt_o !== '0) begin
            if (sb_q.size() == 0) begin
               n_chk++; n_fail++; $display("FAIL b2b_extra_grant: got %b at cycle %0d want none", ifb.gnt_o, cyc);
            end else begin
               e = sb_q.pop_front();
               n_chk++; if (cyc !== e.cyc) begin n_fail++; $display("FAIL b2b_cycle: got %0d want %0d", cyc, e.cyc); end
               n_chk++; if (ifb.gnt_o !== e.gnt) begin n_fail++; $display("FAIL b2b_gnt: got %b want %b", ifb.gnt_o, e.gnt); end
               n_chk++; if (ifb.rnd_o !== e.rnd) begin n_fail++; $display("FAIL b2b_rnd: got %h want %h", ifb.rnd_o, e.rnd); end
               n_chk++; if (b_en !== 1'b1) begin n_fail++; $display("FAIL b2b_en: got %b want 1", b_en); end
            end
         end
         if (cyc >= t + WU + 5) begin
            n_chk++; if (ifb.reseed_req_o !== 1'b1) begin n_fail++; $display("FAIL b2b_stale: got %b want 1 at cycle %0d", ifb.reseed_req_o, cyc); end
         end
         step();
      end
      n_chk++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing: got %0d grants outstanding want 0", sb_q.size()); end
   endtask

   task automatic test_reseed();
      exp_t e;
      int   u;
      logic early_req;
      u = cyc;
      early_req = 1'b0;
      sb_q.delete();
      n_chk++; if ({ifb.reseed_req_o, ifb.seed_ready_o} !== 2'b11) begin n_fail++; $display("FAIL rs_stale_ready: got %b want 11", {ifb.reseed_req_o, ifb.seed_ready_o}); end
      ifb.seed_valid_i = 1'b1; ifb.seed_i = S1;
      step();
      ifb.seed_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e.cyc = u + WU + 2 + i;
         e.gnt = (i == 1) ? 4'b0001 : 4'b0100;
         e.rnd = lfsr_rnd(S1, WU + i);
         sb_q.push_back(e);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (ifb.gnt_o !== '0) begin
            if (sb_q.size() == 0) begin
               n_chk++; n_fail++; $display("FAIL rs_extra_grant: got %b at cycle %0d want none", ifb.gnt_o, cyc);
            end else begin
               e = sb_q.pop_front();
               n_chk++; if (cyc !== e.cyc) begin n_fail++; $display("FAIL rs_cycle: got %0d want %0d", cyc, e.cyc); end
               n_chk++; if (ifb.gnt_o !== e.gnt) begin n_fail++; $display("FAIL rs_gnt: got %b want %b", ifb.gnt_o, e.gnt); end
               n_chk++; if (ifb.rnd_o !== e.rnd) begin n_fail++; $display("FAIL rs_rnd: got %h want %h", ifb.rnd_o, e.rnd); end
            end
         end
         if (cyc < u + WU + 5 && ifb.reseed_req_o !== 1'b0) early_req = 1'b1;
         if (cyc == u + WU + 5) begin
            n_chk++; if (ifb.reseed_req_o !== 1'b1) begin n_fail++; $display("FAIL rs_stale_again: got %b want 1", ifb.reseed_req_o); end
         end
         step();
      end
      n_chk++; if (early_req !== 1'b0) begin n_fail++; $display("FAIL rs_req_cleared: got reseed_req_o=1 before budget spent want 0"); end
      n_chk++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL rs_missing: got %0d grants outstanding want 0", sb_q.size()); end
      ifb.req_i = '0;
   endtask

   initial begin
      test_reset();
      test_warmup_timing();
      test_round_robin();
      test_seed_priority();
      test_reset_mid_stride();
      test_zero_guard();
      test_back_to_back();
      test_reseed();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/prng_rr_scheduler.md
# prng_rr_scheduler

Sequencer and round-robin arbiter for the 128-bit masking PRNG in the masked crypto unit. Accepts seed material, loads and warms up the LFSR, then grants fresh random words to up to NUM_REQ masked-datapath requesters. Between grants it advances the LFSR a programmable stride, and it forces a reseed after a fixed number of grants. It is the only driver of the PRNG's init/enable/seed inputs.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- RND_W, 64: random bits delivered per grant (1..128), taken from prng_i[RND_W-1:0]
- WARMUP, 128: LFSR steps after seed load before first grant (≥1)
- STRIDE, 8: LFSR steps per grant, including the grant cycle (≥1)
- RESEED_INTERVAL, 1024: grants per seed; 0 disables forced reseed
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- seed_valid_i  in  1  seed offered
- seed_ready_o  out  1  seed can be accepted
- seed_i  in  128  seed value
- req_i  in  NUM_REQ  per-requester request, held until granted
- gnt_o  out  NUM_REQ  one-hot grant, one cycle
- rnd_o  out  RND_W  random word, valid when any gnt_o bit is high
- reseed_req_o  out  1  grant budget exhausted, new seed required
- zero_err_o  out  1  all-zero LFSR detected (sticky)
- prng_init_o  out  1  to PRNG init_i
- prng_en_o  out  1  to PRNG en_i
- prng_seed_o  out  128  to PRNG seed_i, registered copy of accepted seed
- prng_i  in  128  PRNG state output

## Operation
- States: UNSEEDED, LOAD, WARMUP, READY, STRIDE, STALE. Reset state: UNSEEDED.
- seed_ready_o = state ∈ {UNSEEDED, READY, STALE}. Handshake: seed_valid_i && seed_ready_o. On the handshake, seed_i is registered into prng_seed_o, grant counter is cleared, zero_err_o is cleared, and the state moves to LOAD.
- LOAD: prng_init_o=1 for one cycle, then WARMUP.
- WARMUP: prng_en_o=1 for exactly WARMUP cycles, then READY.
- READY: if a seed handshake occurs, it wins and no grant is issued. Otherwise, if any req_i is set, grant the first set bit scanning from ptr+1 mod NUM_REQ upward. In that cycle gnt_o[k]=1 (combinational from req_i), rnd_o=prng_i[RND_W-1:0] and prng_en_o=1. Then ptr←k and grant count +1. The state moves to STRIDE if STRIDE>1. Otherwise it stays in READY, or moves to STALE if the count reaches RESEED_INTERVAL.
- STRIDE: prng_en_o=1 for STRIDE-1 cycles, no grants, seed_ready_o=0. Then READY, or STALE if count == RESEED_INTERVAL (RESEED_INTERVAL≠0).
- STALE: reseed_req_o=1, no grants, only a seed handshake exits (to LOAD).
- rnd_o = 0 whenever no grant is active. prng_en_o=0 outside the cases above.
- Grant counter is 32 bits wide and saturates; it never wraps.

## Timing
- Reset values: gnt_o=0, rnd_o=0, reseed_req_o=0, zero_err_o=0, prng_init_o=0, prng_en_o=0, prng_seed_o=0, ptr=NUM_REQ-1 (requester 0 has first priority), count=0. seed_ready_o=1 (UNSEEDED).
- Seed accepted at cycle T: prng_init_o at T+1, warmup enables at T+2..T+1+WARMUP, earliest grant at T+2+WARMUP.
- Grant to grant: minimum STRIDE cycles. With STRIDE=1, back-to-back grants are allowed.
- rst assertion mid-WARMUP/STRIDE: immediate return to UNSEEDED, and all outputs take their reset values asynchronously.
- A requester dropping req_i before its grant is legal and simply receives no grant.

## Configuration
- PRNG_ZERO_GUARD_EN defined: in READY, if prng_i==0, no grant is issued. zero_err_o is set (sticky) and the state moves to UNSEEDED. zero_err_o clears on the next seed handshake.
- Undefined: no zero check, zero_err_o tied 0. Grants proceed with rnd_o=0 when the LFSR is stuck at zero.

## Test plan
- Seed 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, WARMUP=4 -> prng_init_o at T+1, prng_en_o high T+2..T+5, first grant no earlier than T+6.
- req_i=4'b1111 held, STRIDE=8 -> grants to 0,1,2,3,0 in order, exactly 8 cycles apart, each with prng_en_o=1 and rnd_o=prng_i[63:0].
- STRIDE=1, req_i=4'b0101 -> gnt_o alternates 0001, 0100 on consecutive cycles.
- RESEED_INTERVAL=3 -> after the 3rd grant, reseed_req_o=1 and no grants; a new seed clears it, and grants resume WARMUP+2 cycles after the handshake.
- Seed handshake and req_i=4'b0010 in the same READY cycle -> no grant, LOAD entered, ptr unchanged.
- With PRNG_ZERO_GUARD_EN, seed 0 -> after warmup zero_err_o=1, no grant, state UNSEEDED. A nonzero seed clears zero_err_o. rst pulse mid-STRIDE -> all outputs 0, seed_ready_o=1.
